// File: rtl/video_timing_gen_if.sv
// Video output bus between the timing generator and its consumer.
// The pixel source feeds iRGB; everything else is driven by the generator.
interface video_timing_gen_if #(
    parameter int unsigned RGB_W = 15
);
    logic [RGB_W-1:0] iRGB;
    logic [RGB_W-1:0] oRGB;
    logic [8:0]       HPOS;
    logic [8:0]       VPOS;
    logic             HBLK;
    logic             VBLK;
    logic             HSYN;
    logic             VSYN;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  iRGB,
        output oRGB, HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, line_start, frame_start
    );

    modport slave (
        output iRGB,
        input  oRGB, HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, line_start, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: counters, blanking, syncs, flip mapping and blanked pixel register.
// Define VTG_POS_ADJ_EN to add h_adj/v_adj sync-position trim inputs.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 256,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 32,
    parameter int unsigned H_BP     = 72,
    parameter int unsigned V_ACTIVE = 224,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 7,
    parameter int unsigned V_BP     = 29,
    parameter int unsigned RGB_W    = 15
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ce_pix,
    input  logic                     flip,
`ifdef VTG_POS_ADJ_EN
    input  logic signed [3:0]        h_adj,
    input  logic signed [3:0]        v_adj,
`endif
    video_timing_gen_if.master       vid
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        RGB_W == 0 || H_TOTAL > 512 || V_TOTAL > 512) begin : g_bad_params
        $error("video_timing_gen: zero parameter or line/frame total above 512");
    end

    localparam logic [8:0] HA    = 9'(H_ACTIVE);
    localparam logic [8:0] VA    = 9'(V_ACTIVE);
    localparam logic [8:0] HT_M1 = 9'(H_TOTAL - 1);
    localparam logic [8:0] VT_M1 = 9'(V_TOTAL - 1);

    typedef enum logic {StWait, StRun} state_e;

    state_e           state_q, state_d;
    logic [8:0]       hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic             flip_q, flip_d;
    logic             hblk_q, hblk_d, vblk_q, vblk_d;
    logic             hsyn_q, hsyn_d, vsyn_q, vsyn_d;
    logic             ls_q, ls_d, fs_q, fs_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             h_wrap, v_wrap;

`ifdef VTG_POS_ADJ_EN
    localparam int H_TOT_I = int'(H_TOTAL);
    localparam int V_TOT_I = int'(V_TOTAL);
    localparam int HS_LO_I = int'(H_ACTIVE + H_FP);
    localparam int VS_LO_I = int'(V_ACTIVE + V_FP);
    localparam int H_SYNC_I = int'(H_SYNC);
    localparam int V_SYNC_I = int'(V_SYNC);

    logic signed [3:0] h_adj_q, h_adj_d, v_adj_q, v_adj_d;
    int                h_rel, v_rel;
`else
    localparam logic [8:0] HS_LO = 9'(H_ACTIVE + H_FP);
    localparam logic [8:0] HS_HI = 9'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [8:0] VS_LO = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0] VS_HI = 9'(V_ACTIVE + V_FP + V_SYNC - 1);
`endif

    always_comb begin
        state_d = state_q;
        if (ce_pix) state_d = StRun;

        h_wrap = (hcnt_q == HT_M1);
        v_wrap = (vcnt_q == VT_M1);
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        flip_d = flip_q;
`ifdef VTG_POS_ADJ_EN
        h_adj_d = h_adj_q;
        v_adj_d = v_adj_q;
`endif
        // The first pixel enable after reset presents (0,0) instead of advancing past it.
        if (state_q == StRun) begin
            hcnt_d = h_wrap ? '0 : hcnt_q + 9'd1;
            if (h_wrap) vcnt_d = v_wrap ? '0 : vcnt_q + 9'd1;
            if (h_wrap && v_wrap) begin
                flip_d = flip;
`ifdef VTG_POS_ADJ_EN
                h_adj_d = h_adj;
                v_adj_d = v_adj;
`endif
            end
        end

        hblk_d = (hcnt_d >= HA);
        vblk_d = (vcnt_d >= VA);
`ifdef VTG_POS_ADJ_EN
        // Bias by 4x total keeps the dividend positive for any 4-bit trim.
        h_rel  = (int'(hcnt_d) - HS_LO_I - int'(h_adj_d) + 4 * H_TOT_I) % H_TOT_I;
        v_rel  = (int'(vcnt_d) - VS_LO_I - int'(v_adj_d) + 4 * V_TOT_I) % V_TOT_I;
        hsyn_d = !(h_rel < H_SYNC_I);
        vsyn_d = !(v_rel < V_SYNC_I);
`else
        hsyn_d = !(hcnt_d >= HS_LO && hcnt_d <= HS_HI);
        vsyn_d = !(vcnt_d >= VS_LO && vcnt_d <= VS_HI);
`endif

        ls_d = ce_pix && (hcnt_d == '0);
        fs_d = ls_d && (vcnt_d == '0);

        rgb_d = rgb_q;
        if (state_q == StRun) rgb_d = (hblk_q || vblk_q) ? '0 : vid.iRGB;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= StWait;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            flip_q  <= 1'b0;
            hblk_q  <= 1'b0;
            vblk_q  <= 1'b0;
            hsyn_q  <= 1'b1;
            vsyn_q  <= 1'b1;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            rgb_q   <= '0;
`ifdef VTG_POS_ADJ_EN
            h_adj_q <= '0;
            v_adj_q <= '0;
`endif
        end else begin
            ls_q <= ls_d;
            fs_q <= fs_d;
            if (ce_pix) begin
                state_q <= state_d;
                hcnt_q  <= hcnt_d;
                vcnt_q  <= vcnt_d;
                flip_q  <= flip_d;
                hblk_q  <= hblk_d;
                vblk_q  <= vblk_d;
                hsyn_q  <= hsyn_d;
                vsyn_q  <= vsyn_d;
                rgb_q   <= rgb_d;
`ifdef VTG_POS_ADJ_EN
                h_adj_q <= h_adj_d;
                v_adj_q <= v_adj_d;
`endif
            end
        end
    end

    // Flip mirrors only the visible area; blanking reports raw counters.
    assign vid.HPOS        = (flip_q && hcnt_q < HA) ? HA - 9'd1 - hcnt_q : hcnt_q;
    assign vid.VPOS        = (flip_q && vcnt_q < VA) ? VA - 9'd1 - vcnt_q : vcnt_q;
    assign vid.HBLK        = hblk_q;
    assign vid.VBLK        = vblk_q;
    assign vid.HSYN        = hsyn_q;
    assign vid.VSYN        = vsyn_q;
    assign vid.oRGB        = rgb_q;
    assign vid.line_start  = ls_q;
    assign vid.frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a default-size generator for line-level timing and reset behaviour,
// and a small-raster generator for whole-frame behaviour (VSYN, flip, pixel counts).
module tb_video_timing_gen;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ce_pix  = 1'b0;
    logic        flip    = 1'b0;
    logic [14:0] rgb     = 15'h7FFF;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    video_timing_gen_if #(.RGB_W(15)) vif_a ();
    video_timing_gen_if #(.RGB_W(15)) vif_b ();
    assign vif_a.iRGB = rgb;
    assign vif_b.iRGB = rgb;

`ifdef VTG_POS_ADJ_EN
    logic signed [3:0] h_adj_a = 4'sd0;
    logic signed [3:0] v_adj_a = 4'sd0;
    logic signed [3:0] h_adj_b = 4'sd0;
    logic signed [3:0] v_adj_b = 4'sd0;
    localparam int HS1_MIN = 16;
    localparam int HS1_MAX = 21;
    localparam int VS1_MIN = 12;
    localparam int VS1_MAX = 14;
`else
    localparam int HS1_MIN = 20;
    localparam int HS1_MAX = 25;
    localparam int VS1_MIN = 10;
    localparam int VS1_MAX = 12;
`endif

    video_timing_gen u_dut_a (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce_pix  (ce_pix),
        .flip    (flip),
`ifdef VTG_POS_ADJ_EN
        .h_adj   (h_adj_a),
        .v_adj   (v_adj_a),
`endif
        .vid     (vif_a)
    );

    // 32 x 16 raster: HSYN low 20..25, VSYN low lines 10..12, 16 x 8 visible.
    video_timing_gen #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_ACTIVE (8),  .V_FP (2), .V_SYNC (3), .V_BP (3),
        .RGB_W    (15)
    ) u_dut_b (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce_pix  (ce_pix),
        .flip    (flip),
`ifdef VTG_POS_ADJ_EN
        .h_adj   (h_adj_b),
        .v_adj   (v_adj_b),
`endif
        .vid     (vif_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One pixel enable preceded by div-1 idle clocks; returns 1 time unit after the enabled edge.
    task automatic pix(input int div);
        for (int i = 0; i < div - 1; i++) begin
            ce_pix = 1'b0;
            tick();
        end
        ce_pix = 1'b1;
        tick();
    endtask

    int hs_first, hs_last, hs_cnt, hblk_bad, rgb_on, ls_cnt, found;
    int hs_min[2], hs_max[2], vs_min[2], vs_max[2], vs_cnt[2], rgb_cnt[2];
    int vs_bad, blk_bad, ls_wide, fs_cnt;
    logic prev_ls, prev_vs;

    initial begin
        // Reset state, with ce_pix active during reset
        ce_pix = 1'b1;
        tick();
        tick();
        check("rst_hblk",  int'(vif_a.HBLK), 0);
        check("rst_vblk",  int'(vif_a.VBLK), 0);
        check("rst_hsyn",  int'(vif_a.HSYN), 1);
        check("rst_vsyn",  int'(vif_a.VSYN), 1);
        check("rst_orgb",  int'(vif_a.oRGB), 0);
        check("rst_ls",    int'(vif_a.line_start), 0);
        check("rst_fs",    int'(vif_a.frame_start), 0);
        check("rst_hpos",  int'(vif_a.HPOS), 0);
        ce_pix = 1'b0;
        reset  = 1'b0;

        // Default raster, ce_pix every 8th clock
        pix(8);
        check("start_ls",   int'(vif_a.line_start), 1);
        check("start_fs",   int'(vif_a.frame_start), 1);
        check("start_hpos", int'(vif_a.HPOS), 0);
        hs_first = -1; hs_last = -1; hs_cnt = 0; hblk_bad = 0; rgb_on = 0; ls_cnt = 0;
        for (int k = 1; k <= 768; k++) begin
            pix(8);
            if (!vif_a.HSYN && k < 384) begin
                if (hs_first < 0) hs_first = k;
                hs_last = k;
                hs_cnt++;
            end
            if (vif_a.HBLK != ((k % 384) >= 256)) hblk_bad++;
            if (k <= 384 && vif_a.oRGB == 15'h7FFF) rgb_on++;
            if (vif_a.line_start) ls_cnt++;
            if (k == 384) begin
                check("wrap_vpos", int'(vif_a.VPOS), 1);
                check("wrap_hpos", int'(vif_a.HPOS), 0);
                check("wrap_fs",   int'(vif_a.frame_start), 0);
                ce_pix = 1'b0;
                tick();
                check("hold_ls",   int'(vif_a.line_start), 0);
                check("hold_hpos", int'(vif_a.HPOS), 0);
            end
        end
        check("hsyn_first", hs_first, 280);
        check("hsyn_last",  hs_last, 311);
        check("hsyn_width", hs_cnt, 32);
        check("hblk_bad",   hblk_bad, 0);
        check("rgb_line",   rgb_on, 256);
        check("ls_count",   ls_cnt, 2);

        // Asynchronous reset in the middle of an HSYN pulse
        for (int k = 769; k <= 768 + 290; k++) pix(8);
        check("mid_hsyn", int'(vif_a.HSYN), 0);
        check("mid_hpos", int'(vif_a.HPOS), 290);
        #3 reset = 1'b1;
        #1;
        check("async_hsyn", int'(vif_a.HSYN), 1);
        check("async_hpos", int'(vif_a.HPOS), 0);
        check("async_vpos", int'(vif_a.VPOS), 0);
        check("async_hblk", int'(vif_a.HBLK), 0);
        tick();
        reset = 1'b0;
        pix(8);
        found = -1;
        for (int k = 1; k < 400; k++) begin
            pix(8);
            if (!vif_a.HSYN) begin
                found = k;
                check("rel_vpos", int'(vif_a.VPOS), 0);
                break;
            end
        end
        check("rel_hsyn_first", found, 280);

        // Small raster, ce_pix held high, two frames
        ce_pix = 1'b0;
        reset  = 1'b1;
`ifdef VTG_POS_ADJ_EN
        h_adj_b = -4'sd4;
        v_adj_b = 4'sd2;
`endif
        tick();
        reset = 1'b0;
        pix(1);
        check("b_start_fs", int'(vif_b.frame_start), 1);
        for (int f = 0; f < 2; f++) begin
            hs_min[f] = 999; hs_max[f] = -1; vs_min[f] = 999; vs_max[f] = -1;
            vs_cnt[f] = 0; rgb_cnt[f] = 0;
        end
        vs_bad = 0; blk_bad = 0; ls_cnt = 0; ls_wide = 0; fs_cnt = 0;
        prev_ls = vif_b.line_start;
        prev_vs = vif_b.VSYN;
        for (int k = 1; k <= 1024; k++) begin
            int p, h, v, f;
            pix(1);
            p = k % 512;
            h = p % 32;
            v = p / 32;
            f = (k < 512) ? 0 : 1;
            if (k < 1024) begin
                if (!vif_b.HSYN) begin
                    if (h < hs_min[f]) hs_min[f] = h;
                    if (h > hs_max[f]) hs_max[f] = h;
                end
                if (!vif_b.VSYN && h == 0) begin
                    if (v < vs_min[f]) vs_min[f] = v;
                    if (v > vs_max[f]) vs_max[f] = v;
                end
                if (!vif_b.VSYN) vs_cnt[f]++;
            end
            if (vif_b.VSYN != prev_vs && h != 0) vs_bad++;
            prev_vs = vif_b.VSYN;
            if (vif_b.HBLK != (h >= 16) || vif_b.VBLK != (v >= 8)) blk_bad++;
            if (vif_b.oRGB == 15'h7FFF) rgb_cnt[(k - 1) / 512]++;
            if (vif_b.line_start) begin
                ls_cnt++;
                if (prev_ls) ls_wide++;
            end
            prev_ls = vif_b.line_start;
            if (vif_b.frame_start) fs_cnt++;
            case (k)
                128: flip = 1'b1;
                130: begin
                    check("preflip_hpos", int'(vif_b.HPOS), 2);
                    check("preflip_vpos", int'(vif_b.VPOS), 4);
                end
                512: begin
                    check("flip_first_hpos", int'(vif_b.HPOS), 15);
                    check("flip_first_vpos", int'(vif_b.VPOS), 7);
                end
                527: check("flip_h15_hpos", int'(vif_b.HPOS), 0);
                532: check("flip_hblk_hpos", int'(vif_b.HPOS), 20);
                803: begin
                    check("flip_vblk_hpos", int'(vif_b.HPOS), 12);
                    check("flip_vblk_vpos", int'(vif_b.VPOS), 9);
                end
                default: ;
            endcase
        end
        check("b_hs_min0", hs_min[0], 20);
        check("b_hs_max0", hs_max[0], 25);
        check("b_hs_min1", hs_min[1], HS1_MIN);
        check("b_hs_max1", hs_max[1], HS1_MAX);
        check("b_vs_min0", vs_min[0], 10);
        check("b_vs_max0", vs_max[0], 12);
        check("b_vs_min1", vs_min[1], VS1_MIN);
        check("b_vs_max1", vs_max[1], VS1_MAX);
        check("b_vs_cnt0", vs_cnt[0], 96);
        check("b_vs_cnt1", vs_cnt[1], 96);
        check("b_vs_edge", vs_bad, 0);
        check("b_blk_bad", blk_bad, 0);
        check("b_rgb0",    rgb_cnt[0], 128);
        check("b_rgb1",    rgb_cnt[1], 128);
        check("b_ls_cnt",  ls_cnt, 32);
        check("b_ls_wide", ls_wide, 0);
        check("b_fs_cnt",  fs_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
